// File: rtl/cluster_event_pkg.sv
// Shared types and field-layout helpers for the cluster event collector.
// Field offsets are derived from the per-source event counts.
package cluster_event_pkg;

  localparam int unsigned EVT_WIDTH_DFLT = 32;

  typedef logic [EVT_WIDTH_DFLT-1:0] evt_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } evt_state_e;

  // Bit 0 is sync/barrier/fifo, bit 1 is dispatch, then DMA and timer fields.
  function automatic int unsigned dma_off();
    return 32'd2;
  endfunction

  function automatic int unsigned timer_off(input int unsigned nb_dma);
    return 32'(2 + nb_dma);
  endfunction

  // Two reserved bits sit between the timer and accelerator fields.
  function automatic int unsigned acc_off(input int unsigned nb_dma, input int unsigned nb_timer);
    return 32'(2 + nb_dma + nb_timer + 2);
  endfunction

  function automatic int unsigned cluster_off(input int unsigned evt_w, input int unsigned nb_cl);
    return 32'(evt_w - nb_cl);
  endfunction

endpackage

// File: rtl/cluster_event_core_ctrl.sv
// One core's event channel: sticky pending bits, irq mask, overflow flag
// and the wait/ack handshake that consumes matched events.
module cluster_event_core_ctrl
  import cluster_event_pkg::*;
#(
  parameter int unsigned            EVT_WIDTH = EVT_WIDTH_DFLT,
  parameter logic [EVT_WIDTH-1:0]   MASK_RST  = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [EVT_WIDTH-1:0] raw_i,
  input  logic                 mask_we_i,
  input  logic [EVT_WIDTH-1:0] mask_wdata_i,
  input  logic [EVT_WIDTH-1:0] clr_i,
  input  logic                 wait_req_i,
  input  logic [EVT_WIDTH-1:0] wait_mask_i,
  output logic                 wait_ack_o,
  output logic [EVT_WIDTH-1:0] wait_evt_o,
  output logic [EVT_WIDTH-1:0] pending_o,
  output logic                 irq_o,
  output logic                 overflow_o
);

  evt_state_e           state_q, state_d;
  logic [EVT_WIDTH-1:0] pending_q, pending_d;
  logic [EVT_WIDTH-1:0] mask_q, mask_d;
  logic [EVT_WIDTH-1:0] wmask_q, wmask_d;
  logic [EVT_WIDTH-1:0] evt_q, evt_d;
  logic                 overflow_q, overflow_d;
  logic [EVT_WIDTH-1:0] consume;
  logic [EVT_WIDTH-1:0] hit;
  logic [EVT_WIDTH-1:0] early_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mask_q     <= MASK_RST;
      wmask_q    <= '0;
      evt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      wmask_q    <= wmask_d;
      evt_q      <= evt_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake FSM; evt_q is only non-zero while in ACK.
  always_comb begin
    state_d   = state_q;
    wmask_d   = wmask_q;
    evt_d     = '0;
    consume   = '0;
    hit       = pending_q & wmask_q;
    early_hit = pending_q & wait_mask_i;
    unique case (state_q)
      IDLE: begin
        if (wait_req_i) begin
          wmask_d = wait_mask_i;
          if (|early_hit) begin
            state_d = ACK;
            consume = early_hit;
            evt_d   = early_hit;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wait_req_i) begin
          state_d = IDLE;
        end else if (|hit) begin
          state_d = ACK;
          consume = hit;
          evt_d   = hit;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New events win over clear and consume in the same cycle.
  always_comb begin
    pending_d  = (pending_q & ~clr_i & ~consume) | raw_i;
    overflow_d = (overflow_q & ~clr_i[0]) | (|(raw_i & pending_q & ~clr_i & ~consume));
    mask_d     = mask_we_i ? mask_wdata_i : mask_q;
  end

  assign wait_ack_o = (state_q == ACK);
  assign wait_evt_o = evt_q;
  assign pending_o  = pending_q;
  assign irq_o      = |(pending_q & mask_q);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/cluster_event_collector.sv
// Packs per-core event sources into an event word and feeds one
// cluster_event_core_ctrl channel per core.
module cluster_event_collector
  import cluster_event_pkg::*;
#(
  parameter int unsigned          NB_CORES       = 1,
  parameter int unsigned          NB_DMA_EVT     = 2,
  parameter int unsigned          NB_TIMER_EVT   = 2,
  parameter int unsigned          NB_ACC_EVT     = 4,
  parameter int unsigned          NB_CLUSTER_EVT = 16,
  parameter int unsigned          EVT_WIDTH      = EVT_WIDTH_DFLT,
  parameter logic [EVT_WIDTH-1:0] MASK_RST       = '1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NB_CORES-1:0]                         barrier_evt_i,
  input  logic [NB_CORES-1:0]                         mutex_evt_i,
  input  logic                                        periph_fifo_evt_i,
  input  logic [NB_CORES-1:0]                         dispatch_evt_i,
  input  logic [NB_CORES-1:0][NB_DMA_EVT-1:0]         dma_evt_i,
  input  logic [NB_CORES-1:0][NB_TIMER_EVT-1:0]       timer_evt_i,
  input  logic [NB_CORES-1:0][NB_ACC_EVT-1:0]         acc_evt_i,
  input  logic [NB_CORES-1:0][NB_CLUSTER_EVT-1:0]     cluster_evt_i,
  input  logic [NB_CORES-1:0]                         mask_we_i,
  input  logic [NB_CORES-1:0][EVT_WIDTH-1:0]          mask_wdata_i,
  input  logic [NB_CORES-1:0][EVT_WIDTH-1:0]          clr_i,
  input  logic [NB_CORES-1:0]                         wait_req_i,
  input  logic [NB_CORES-1:0][EVT_WIDTH-1:0]          wait_mask_i,
  output logic [NB_CORES-1:0]                         wait_ack_o,
  output logic [NB_CORES-1:0][EVT_WIDTH-1:0]          wait_evt_o,
  output logic [NB_CORES-1:0][EVT_WIDTH-1:0]          pending_o,
  output logic [NB_CORES-1:0]                         irq_o,
  output logic [NB_CORES-1:0]                         overflow_o
);

  localparam int unsigned DMA_OFF   = dma_off();
  localparam int unsigned TIMER_OFF = timer_off(NB_DMA_EVT);
  localparam int unsigned ACC_OFF   = acc_off(NB_DMA_EVT, NB_TIMER_EVT);
  localparam int unsigned ACC_END   = ACC_OFF + NB_ACC_EVT;
  localparam int unsigned CL_OFF    = cluster_off(EVT_WIDTH, NB_CLUSTER_EVT);

  if ((NB_CLUSTER_EVT > EVT_WIDTH) || (ACC_END > CL_OFF)) begin : g_bad_layout
    $error("cluster_event_collector: event fields overlap or exceed EVT_WIDTH");
  end

  logic [NB_CORES-1:0][EVT_WIDTH-1:0] raw;

  // Raw event word per core; the fifo pulse is broadcast to every core.
  always_comb begin
    for (int unsigned c = 0; c < NB_CORES; c++) begin
      raw[c]                                = '0;
      raw[c][0]                             = barrier_evt_i[c] | mutex_evt_i[c] | periph_fifo_evt_i;
      raw[c][1]                             = dispatch_evt_i[c];
      raw[c][DMA_OFF +: NB_DMA_EVT]         = dma_evt_i[c];
      raw[c][TIMER_OFF +: NB_TIMER_EVT]     = timer_evt_i[c];
      raw[c][ACC_OFF +: NB_ACC_EVT]         = acc_evt_i[c];
      raw[c][CL_OFF +: NB_CLUSTER_EVT]      = cluster_evt_i[c];
    end
  end

  for (genvar g = 0; g < NB_CORES; g++) begin : g_core
    cluster_event_core_ctrl #(
      .EVT_WIDTH (EVT_WIDTH),
      .MASK_RST  (MASK_RST)
    ) u_core_ctrl (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .raw_i        (raw[g]),
      .mask_we_i    (mask_we_i[g]),
      .mask_wdata_i (mask_wdata_i[g]),
      .clr_i        (clr_i[g]),
      .wait_req_i   (wait_req_i[g]),
      .wait_mask_i  (wait_mask_i[g]),
      .wait_ack_o   (wait_ack_o[g]),
      .wait_evt_o   (wait_evt_o[g]),
      .pending_o    (pending_o[g]),
      .irq_o        (irq_o[g]),
      .overflow_o   (overflow_o[g])
    );
  end

endmodule

// File: tb/tb_cluster_event_collector.sv
// Directed bench for cluster_event_collector with four cores; core 0
// carries most scenarios, cores 1-3 cover broadcast and reset-mid-wait.
module tb_cluster_event_collector;
  import cluster_event_pkg::*;

  localparam int unsigned NC = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic [NC-1:0]             barrier_evt_i;
  logic [NC-1:0]             mutex_evt_i;
  logic                      periph_fifo_evt_i;
  logic [NC-1:0]             dispatch_evt_i;
  logic [NC-1:0][1:0]        dma_evt_i;
  logic [NC-1:0][1:0]        timer_evt_i;
  logic [NC-1:0][3:0]        acc_evt_i;
  logic [NC-1:0][15:0]       cluster_evt_i;
  logic [NC-1:0]             mask_we_i;
  logic [NC-1:0][31:0]       mask_wdata_i;
  logic [NC-1:0][31:0]       clr_i;
  logic [NC-1:0]             wait_req_i;
  logic [NC-1:0][31:0]       wait_mask_i;
  logic [NC-1:0]             wait_ack_o;
  logic [NC-1:0][31:0]       wait_evt_o;
  logic [NC-1:0][31:0]       pending_o;
  logic [NC-1:0]             irq_o;
  logic [NC-1:0]             overflow_o;

  int checks = 0;
  int errors = 0;

  cluster_event_collector #(.NB_CORES(NC)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .barrier_evt_i     (barrier_evt_i),
    .mutex_evt_i       (mutex_evt_i),
    .periph_fifo_evt_i (periph_fifo_evt_i),
    .dispatch_evt_i    (dispatch_evt_i),
    .dma_evt_i         (dma_evt_i),
    .timer_evt_i       (timer_evt_i),
    .acc_evt_i         (acc_evt_i),
    .cluster_evt_i     (cluster_evt_i),
    .mask_we_i         (mask_we_i),
    .mask_wdata_i      (mask_wdata_i),
    .clr_i             (clr_i),
    .wait_req_i        (wait_req_i),
    .wait_mask_i       (wait_mask_i),
    .wait_ack_o        (wait_ack_o),
    .wait_evt_o        (wait_evt_o),
    .pending_o         (pending_o),
    .irq_o             (irq_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_all();
    for (int c = 0; c < NC; c++) clr_i[c] = '1;
    tick();
    clr_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (pending_o[0] !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending_o[0]); end
    checks++;
    if (irq_o !== 4'h0 || overflow_o !== 4'h0 || wait_ack_o !== 4'h0) begin
      errors++; $display("FAIL reset_flags irq %b ovf %b ack %b exp 0", irq_o, overflow_o, wait_ack_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_dma();
    dma_evt_i[0] = 2'b01;
    tick();
    dma_evt_i[0] = 2'b00;
    checks++;
    if (pending_o[0] !== 32'h4) begin errors++; $display("FAIL dma_pending got %h exp 00000004", pending_o[0]); end
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL dma_irq got %b exp 1", irq_o[0]); end
    clear_all();
  endtask

  task automatic test_mask_gate();
    mask_we_i[0] = 1'b1;
    mask_wdata_i[0] = 32'h0;
    tick();
    mask_we_i[0] = 1'b0;
    acc_evt_i[0] = 4'b1000;
    tick();
    acc_evt_i[0] = 4'b0000;
    checks++;
    if (pending_o[0] !== 32'h800) begin errors++; $display("FAIL acc_pending got %h exp 00000800", pending_o[0]); end
    checks++;
    if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp 0", irq_o[0]); end
    mask_we_i[0] = 1'b1;
    mask_wdata_i[0] = 32'hFFFF_FFFF;
    tick();
    mask_we_i[0] = 1'b0;
    checks++;
    if (irq_o[0] !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b exp 1", irq_o[0]); end
    clear_all();
  endtask

  task automatic test_wait_immediate();
    dma_evt_i[0] = 2'b01;
    tick();
    dma_evt_i[0] = 2'b00;
    wait_req_i[0] = 1'b1;
    wait_mask_i[0] = 32'hC;
    tick();
    wait_req_i[0] = 1'b0;
    checks++;
    if (wait_ack_o[0] !== 1'b1 || wait_evt_o[0] !== 32'h4) begin
      errors++; $display("FAIL imm_ack ack %b evt %h exp 1 00000004", wait_ack_o[0], wait_evt_o[0]);
    end
    checks++;
    if (pending_o[0] !== 32'h0) begin errors++; $display("FAIL imm_consume got %h exp 0", pending_o[0]); end
    tick();
    checks++;
    if (wait_ack_o[0] !== 1'b0 || wait_evt_o[0] !== 32'h0) begin
      errors++; $display("FAIL imm_ack_drop ack %b evt %h exp 0 0", wait_ack_o[0], wait_evt_o[0]);
    end
  endtask

  task automatic test_wait_cluster();
    wait_req_i[0] = 1'b1;
    wait_mask_i[0] = 32'h1_0000;
    tick();
    tick();
    checks++;
    if (wait_ack_o[0] !== 1'b0) begin errors++; $display("FAIL wait_idle_ack got %b exp 0", wait_ack_o[0]); end
    cluster_evt_i[0] = 16'h0001;
    tick();
    cluster_evt_i[0] = 16'h0000;
    checks++;
    if (wait_ack_o[0] !== 1'b0 || pending_o[0] !== 32'h1_0000) begin
      errors++; $display("FAIL wait_t1 ack %b pend %h exp 0 00010000", wait_ack_o[0], pending_o[0]);
    end
    tick();
    wait_req_i[0] = 1'b0;
    checks++;
    if (wait_ack_o[0] !== 1'b1 || wait_evt_o[0] !== 32'h1_0000 || pending_o[0] !== 32'h0) begin
      errors++;
      $display("FAIL wait_t2 ack %b evt %h pend %h exp 1 00010000 0", wait_ack_o[0], wait_evt_o[0], pending_o[0]);
    end
    tick();
  endtask

  task automatic test_overflow();
    barrier_evt_i[0] = 1'b1;
    tick();
    barrier_evt_i[0] = 1'b0;
    tick();
    barrier_evt_i[0] = 1'b1;
    tick();
    barrier_evt_i[0] = 1'b0;
    checks++;
    if (overflow_o[0] !== 1'b1 || pending_o[0] !== 32'h1) begin
      errors++; $display("FAIL ovf_set ovf %b pend %h exp 1 00000001", overflow_o[0], pending_o[0]);
    end
    clr_i[0] = 32'h1;
    tick();
    clr_i[0] = 32'h0;
    checks++;
    if (overflow_o[0] !== 1'b0 || pending_o[0] !== 32'h0) begin
      errors++; $display("FAIL ovf_clr ovf %b pend %h exp 0 0", overflow_o[0], pending_o[0]);
    end
    barrier_evt_i[0] = 1'b1;
    tick();
    clr_i[0] = 32'h1;
    tick();
    clr_i[0] = 32'h0;
    barrier_evt_i[0] = 1'b0;
    checks++;
    if (pending_o[0] !== 32'h1 || overflow_o[0] !== 1'b0) begin
      errors++; $display("FAIL set_beats_clr pend %h ovf %b exp 00000001 0", pending_o[0], overflow_o[0]);
    end
    clear_all();
  endtask

  task automatic test_broadcast();
    periph_fifo_evt_i = 1'b1;
    tick();
    periph_fifo_evt_i = 1'b0;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (pending_o[c] !== 32'h1) begin
        errors++; $display("FAIL bcast_core%0d got %h exp 00000001", c, pending_o[c]);
      end
    end
    clear_all();
  endtask

  task automatic test_reset_mid_wait();
    dispatch_evt_i[1] = 1'b1;
    wait_req_i[2] = 1'b1;
    wait_mask_i[2] = 32'h100;
    tick();
    dispatch_evt_i[1] = 1'b0;
    tick();
    acc_evt_i[2] = 4'b0001;
    rst_i = 1'b1;
    tick();
    acc_evt_i[2] = 4'b0000;
    checks++;
    if (wait_ack_o !== 4'h0 || pending_o !== '0) begin
      errors++; $display("FAIL rst_wait ack %b pend1 %h pend2 %h exp 0", wait_ack_o, pending_o[1], pending_o[2]);
    end
    wait_req_i[2] = 1'b0;
    rst_i = 1'b0;
    tick();
    checks++;
    if (wait_ack_o !== 4'h0 || wait_evt_o !== '0 || irq_o !== 4'h0 || overflow_o !== 4'h0) begin
      errors++; $display("FAIL rst_after ack %b irq %b ovf %b exp 0", wait_ack_o, irq_o, overflow_o);
    end
    acc_evt_i[2] = 4'b0001;
    tick();
    acc_evt_i[2] = 4'b0000;
    checks++;
    if (pending_o[2] !== 32'h100 || irq_o !== 4'b0100) begin
      errors++; $display("FAIL rst_mask pend %h irq %b exp 00000100 0100", pending_o[2], irq_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    barrier_evt_i = '0;
    mutex_evt_i = '0;
    periph_fifo_evt_i = 1'b0;
    dispatch_evt_i = '0;
    dma_evt_i = '0;
    timer_evt_i = '0;
    acc_evt_i = '0;
    cluster_evt_i = '0;
    mask_we_i = '0;
    mask_wdata_i = '0;
    clr_i = '0;
    wait_req_i = '0;
    wait_mask_i = '0;
    test_reset();
    test_dma();
    test_mask_gate();
    test_wait_immediate();
    test_wait_cluster();
    test_overflow();
    test_broadcast();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
